// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: MEM pipeline stage with a load/store unit.
//
// Non-memory instructions pass straight through to the MEM/WB register with
// no added latency. A valid load or store freezes the front of the pipeline.
// The EX/MEM fields are captured, one request is placed on the data bus, and
// the stage waits for the response. It then presents the result for exactly
// one DONE cycle. Stores also wait for a write acknowledge on dmem_rvalid.
// If no response arrives within RESP_TIMEOUT cycles, the access is aborted
// and flagged on mem_bus_err_out.
//
// Optional build macro:
//   LSU_MISALIGN_CHECK_EN - when defined, a misaligned halfword or word access
//   never reaches the bus. It completes at once as an error with no register
//   write. When undefined, the low address bits only select lanes.
module mem_lsu_stage #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ex_valid_in,
    input  logic [31:0] ex_alu_result_in,
    input  logic [31:0] ex_store_data_in,
    input  logic [31:0] ex_pc_plus_4_in,
    input  logic [4:0]  ex_rd_addr_in,
    input  logic        ex_reg_write_en_in,
    input  logic [1:0]  ex_mem_to_reg_in,
    input  logic        ex_mem_read_in,
    input  logic        ex_mem_write_in,
    input  logic [2:0]  ex_funct3_in,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,

    output logic [31:0] mem_alu_result_out,
    output logic [31:0] mem_load_data_out,
    output logic [31:0] mem_pc_plus_4_out,
    output logic [4:0]  mem_rd_addr_out,
    output logic        mem_reg_write_en_out,
    output logic [1:0]  mem_mem_to_reg_out,
    output logic        mem_stall_out,
    output logic        mem_bus_err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_TIMEOUT - 1);

    state_t state, state_nxt;

    // Fields captured from EX/MEM when a memory access starts
    logic [31:0] alu_result_p0;
    logic [31:0] store_data_p0;
    logic [31:0] pc_plus_4_p0;
    logic [4:0]  rd_addr_p0;
    logic        reg_write_en_p0;
    logic [1:0]  mem_to_reg_p0;
    logic        mem_write_p0;
    logic [2:0]  funct3_p0;

    // Access progress: response word, abort flag, cycles spent on the bus
    logic [31:0]      rdata_p0;
    logic             err_p0;
    logic [CNT_W-1:0] timeout_cnt;

    logic mem_op;
    logic misalign;
    logic timeout_hit;

    // Pick the addressed lane out of the read word and extend it to 32 bits
    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [1:0] a,
                                                 input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = 32'(b);
            3'b001:  load_extract = 32'(h);
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = w;
        endcase
    endfunction

    // Byte enables for the addressed lane(s) of a store
    function automatic logic [3:0] store_be(input logic [2:0] f3,
                                            input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << a;
            2'b01:   store_be = a[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicate store data across lanes so the enabled lanes carry it
    function automatic logic [31:0] store_wdata(input logic [2:0] f3,
                                                input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_wdata = {4{d[7:0]}};
            2'b01:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=00
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] a);
        case (f3[1:0])
            2'b01:   is_misaligned = a[0];
            2'b10:   is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    assign misalign = is_misaligned(ex_funct3_in, ex_alu_result_in[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign mem_op      = ex_valid_in & (ex_mem_read_in | ex_mem_write_in);
    assign timeout_hit = (timeout_cnt == CNT_LAST);

    // Bus signals are driven from captured fields so they hold steady until grant
    assign dmem_req   = (state == REQ);
    assign dmem_we    = (state == REQ) & mem_write_p0;
    assign dmem_addr  = {alu_result_p0[31:2], 2'b00};
    assign dmem_be    = store_be(funct3_p0, alu_result_p0[1:0]);
    assign dmem_wdata = store_wdata(funct3_p0, store_data_p0);

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and MEM/WB-side outputs
    always_comb begin
        state_nxt            = state;
        mem_stall_out        = 1'b0;
        mem_bus_err_out      = 1'b0;
        mem_alu_result_out   = ex_alu_result_in;
        mem_load_data_out    = 32'd0;
        mem_pc_plus_4_out    = ex_pc_plus_4_in;
        mem_rd_addr_out      = ex_rd_addr_in;
        mem_reg_write_en_out = ex_valid_in & ex_reg_write_en_in;
        mem_mem_to_reg_out   = ex_mem_to_reg_in;

        case (state)
            IDLE: begin
                if (mem_op) begin
                    mem_stall_out        = 1'b1;
                    mem_reg_write_en_out = 1'b0;
                    state_nxt            = misalign ? DONE : REQ;
                end
            end
            REQ, WAIT: begin
                mem_stall_out        = 1'b1;
                mem_alu_result_out   = alu_result_p0;
                mem_pc_plus_4_out    = pc_plus_4_p0;
                mem_rd_addr_out      = rd_addr_p0;
                mem_reg_write_en_out = 1'b0;
                mem_mem_to_reg_out   = mem_to_reg_p0;
                // A completing response beats the timeout in the same cycle
                if (state == REQ) begin
                    if (dmem_gnt && dmem_rvalid) state_nxt = DONE;
                    else if (timeout_hit)        state_nxt = DONE;
                    else if (dmem_gnt)           state_nxt = WAIT;
                end else begin
                    if (dmem_rvalid || timeout_hit) state_nxt = DONE;
                end
            end
            DONE: begin
                mem_alu_result_out   = alu_result_p0;
                mem_pc_plus_4_out    = pc_plus_4_p0;
                mem_rd_addr_out      = rd_addr_p0;
                mem_reg_write_en_out = reg_write_en_p0 & ~err_p0;
                mem_mem_to_reg_out   = mem_to_reg_p0;
                mem_bus_err_out      = err_p0;
                if (!err_p0 && !mem_write_p0) begin
                    mem_load_data_out = load_extract(funct3_p0, alu_result_p0[1:0], rdata_p0);
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the EX/MEM fields when an access is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_p0   <= 32'd0;
            store_data_p0   <= 32'd0;
            pc_plus_4_p0    <= 32'd0;
            rd_addr_p0      <= 5'd0;
            reg_write_en_p0 <= 1'b0;
            mem_to_reg_p0   <= 2'd0;
            mem_write_p0    <= 1'b0;
            funct3_p0       <= 3'd0;
        end else if (state == IDLE && mem_op) begin
            alu_result_p0   <= ex_alu_result_in;
            store_data_p0   <= ex_store_data_in;
            pc_plus_4_p0    <= ex_pc_plus_4_in;
            rd_addr_p0      <= ex_rd_addr_in;
            reg_write_en_p0 <= ex_reg_write_en_in;
            mem_to_reg_p0   <= ex_mem_to_reg_in;
            mem_write_p0    <= ex_mem_write_in;
            funct3_p0       <= ex_funct3_in;
        end
    end

    // Timeout counter, abort flag and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
            err_p0      <= 1'b0;
            rdata_p0    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        timeout_cnt <= '0;
                        rdata_p0    <= 32'd0;
                        err_p0      <= misalign;
                    end
                end
                REQ: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (dmem_gnt && dmem_rvalid) begin
                        if (!mem_write_p0) rdata_p0 <= dmem_rdata;
                    end else if (timeout_hit) begin
                        err_p0 <= 1'b1;
                    end
                end
                WAIT: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (dmem_rvalid) begin
                        if (!mem_write_p0) rdata_p0 <= dmem_rdata;
                    end else if (timeout_hit) begin
                        err_p0 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_lsu_stage.md
MEM_LSU_STAGE -- requirements
Module: mem_lsu_stage

Interface
REQ-001 Parameter RESP_TIMEOUT, default 64: max cycles from entering REQ to dmem_rvalid before the access aborts.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ex_valid_in  input  1  EX/MEM slot holds a real instruction.
REQ-005 ex_alu_result_in  input  32  ALU result / effective address.
REQ-006 ex_store_data_in  input  32  rs2 data for stores.
REQ-007 ex_pc_plus_4_in  input  32  return address for JAL/JALR.
REQ-008 ex_rd_addr_in  input  5  destination register.
REQ-009 ex_reg_write_en_in  input  1  register write enable.
REQ-010 ex_mem_to_reg_in  input  2  writeback select: 00 ALU, 01 load, 10 PC+4.
REQ-011 ex_mem_read_in / ex_mem_write_in  input  1 each  load / store.
REQ-012 ex_funct3_in  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-013 dmem_req, dmem_we  output  1 each  bus request, write strobe.
REQ-014 dmem_addr  output  32  word-aligned address (bits[1:0]=00).
REQ-015 dmem_wdata  output  32; dmem_be  output  4  lane-replicated store data, byte enables.
REQ-016 dmem_gnt  input  1  request accepted; dmem_rvalid  input  1  response/ack; dmem_rdata  input  32  read word.
REQ-017 mem_alu_result_out, mem_load_data_out, mem_pc_plus_4_out  output  32 each  to MEM/WB register.
REQ-018 mem_rd_addr_out 5, mem_reg_write_en_out 1, mem_mem_to_reg_out 2  output  to MEM/WB register.
REQ-019 mem_stall_out  output  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-020 mem_bus_err_out  output  1  one-cycle pulse on timeout abort.

Function
REQ-021 FSM states IDLE, REQ, WAIT, DONE.
REQ-022 IDLE, ex_valid_in=1, no mem op: outputs pass inputs through combinationally, mem_load_data_out=0, stall=0.
REQ-023 IDLE, ex_valid_in=0: mem_reg_write_en_out=0 (bubble), stall=0.
REQ-024 IDLE, valid load or store: latch all EX fields, go REQ; stall=1, mem_reg_write_en_out=0 this cycle.
REQ-025 REQ: dmem_req=1 with stable addr/we/wdata/be until the cycle dmem_gnt=1; then WAIT, or DONE if dmem_rvalid also 1 that cycle.
REQ-026 WAIT: dmem_req=0; on dmem_rvalid capture dmem_rdata, go DONE.
REQ-027 Stores also wait for dmem_rvalid (write ack); rdata ignored.
REQ-028 DONE: outputs present latched fields plus extracted load data for exactly one cycle, stall=0; next state IDLE.
REQ-029 mem_stall_out=1 in REQ, WAIT and the IDLE cycle of REQ-024; 0 otherwise.
REQ-030 Load extract: byte lane addr[1:0], halfword lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-031 Store: B -> be=0001<<addr[1:0], data byte replicated x4; H -> be=0011<<(2*addr[1]), half replicated x2; W -> be=1111.
REQ-032 Timeout counter clears on REQ entry, increments each REQ/WAIT cycle; at RESP_TIMEOUT go DONE, load data=0, mem_reg_write_en_out=0, mem_bus_err_out=1 that DONE cycle.
REQ-033 dmem_rvalid or dmem_gnt outside REQ/WAIT ignored.
REQ-034 Outputs for IDLE pass-through and DONE are glitch-free functions of state and registers; no extra latency for non-memory ops.

Reset
REQ-035 rst_n low: state IDLE, all latched fields, counter and captured rdata clear to 0, immediately.
REQ-036 Reset mid-access (REQ/WAIT) drops dmem_req same cycle; the access is abandoned, no DONE issued.

Configuration
REQ-037 Macro LSU_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=00 skips the bus, goes directly to DONE with mem_reg_write_en_out=0 and mem_bus_err_out=1.
REQ-038 Undefined: no check; misaligned address bits are ignored per REQ-030/031 lane rules.

Verification
REQ-039 ALU op rd=5, result 0x1234 -> same cycle mem_alu_result_out=0x1234, reg_write_en=1, stall=0.
REQ-040 LB addr 0x1003, gnt cycle 2, rvalid cycle 4, rdata 0x80FF_FF00 -> stall cycles 1-4, DONE load_data 0xFFFF_FF80.
REQ-041 SH addr 0x2002, data 0xABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1 until gnt.
REQ-042 LW, gnt and rvalid never asserted -> after 64 cycles one DONE cycle, bus_err=1, reg_write_en=0, then IDLE.
REQ-043 rst_n low during WAIT -> dmem_req=0, stall=0, later rvalid ignored.
REQ-044 With LSU_MISALIGN_CHECK_EN, LW addr 0x0002 -> dmem_req never asserted, bus_err pulse, no write.
